// File: rtl/dmem_resp_pkg.sv
// -----------------------------------------------------------------------------
// dmem_resp_pkg
// Shared definitions for the data-memory responder:
//   - access size encodings (SZ_B / SZ_H / SZ_W; 2'd3 is reserved and faults)
//   - FSM state type (IDLE / ACC / ACC2 / RESP)
//   - MISALIGN_TRAP_EN, derived from the build macro DMEM_MISALIGN_TRAP_EN
//   - lane mask and load-extension helpers
// -----------------------------------------------------------------------------
package dmem_resp_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACC2 = 2'd2,
        RESP = 2'd3
    } state_t;

    // When DMEM_MISALIGN_TRAP_EN is defined, misaligned half/word accesses
    // fault instead of being split across two words.
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP_EN = 1'b1;
`else
    localparam bit MISALIGN_TRAP_EN = 1'b0;
`endif

    // Byte lanes touched by an access of the given size, before offset shift.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001;
            SZ_H:    m = 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Sign- or zero-extend a right-aligned load value.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [31:0] r;
        case (size)
            SZ_B:    r = {{24{~uns & raw[7]}},  raw[7:0]};
            SZ_H:    r = {{16{~uns & raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Word-organised storage with four byte-lane write enables and a registered
// (one-cycle) read port. Contents are not reset.
// Ports:
//   clk    in   clock
//   addr   in   word address (read and write share it)
//   be     in   byte-lane write enables, bit i writes wdata[8i+7:8i]
//   wdata  in   write data, lane-aligned
//   rdata  out  word read at addr on the previous rising edge (old data on
//               a simultaneous write)
// -----------------------------------------------------------------------------
module dmem_ram #(
    parameter int WORDS = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
// Data-memory responder: one outstanding load/store over valid/ready request
// and response channels. Little-endian, byte addressable, word organised.
// Accesses crossing a word boundary take an extra cycle (ACC2) unless the
// build defines DMEM_MISALIGN_TRAP_EN, in which case they fault.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_addr            byte address; bits above ADDR_W must be zero
//   req_we              1 = store, 0 = load
//   req_size            0 byte, 1 half, 2 word, 3 reserved (fault)
//   req_unsigned        zero-extend loads
//   req_wdata           right-aligned store data
//   rsp_valid/ready     response handshake; fields hold until accepted
//   rsp_rdata           extended load data, 0 for stores and faults
//   rsp_err             access fault
// Latency from accept edge T: rsp_valid at T+2, or T+3 when split.
// -----------------------------------------------------------------------------
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_BYTES = 65536,
    parameter int ADDR_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WORD_AW = ADDR_W - 2;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                span_q, span_d;
    logic [31:0]         lo_word_q, lo_word_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                req_misalign_s;
    logic                req_err_s;
    logic                req_span_s;
    logic [WORD_AW-1:0]  word_s;
    logic [WORD_AW-1:0]  ram_addr_s;
    logic [3:0]          ram_be_s;
    logic [31:0]         ram_wdata_s;
    logic [31:0]         ram_rdata_s;
    logic [63:0]         wide_wdata_s;
    logic [7:0]          wide_be_s;
    logic [31:0]         lo_s;
    logic [31:0]         raw_s;

    // Request classification, evaluated on the live request inputs.
    always_comb begin
        req_misalign_s = ((req_size == SZ_H) && req_addr[0]) ||
                         ((req_size == SZ_W) && (req_addr[1:0] != 2'd0));
        req_err_s      = (|req_addr[31:ADDR_W]) || (req_size == 2'd3) ||
                         (MISALIGN_TRAP_EN && req_misalign_s);
        // Only a misaligned half at offset 3 or a misaligned word crosses
        // into the next word; a faulting request never splits.
        req_span_s     = !req_err_s &&
                         (((req_size == SZ_H) && (req_addr[1:0] == 2'd3)) ||
                          ((req_size == SZ_W) && (req_addr[1:0] != 2'd0)));
    end

    // Store lane placement: the 64-bit window covers the word and word+1.
    always_comb begin
        wide_wdata_s = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
        wide_be_s    = {4'd0, size_mask(size_q)} << addr_q[1:0];
    end

    // RAM port drive: ACC uses the base word, ACC2 the next word (wrapping).
    always_comb begin
        word_s      = addr_q[ADDR_W-1:2];
        ram_addr_s  = word_s;
        ram_be_s    = 4'b0000;
        ram_wdata_s = wide_wdata_s[31:0];
        if (state_q == ACC2) begin
            ram_addr_s  = word_s + WORD_AW'(1);
            ram_wdata_s = wide_wdata_s[63:32];
            ram_be_s    = (we_q && !err_q) ? wide_be_s[7:4] : 4'b0000;
        end else if (state_q == ACC) begin
            ram_be_s    = (we_q && !err_q) ? wide_be_s[3:0] : 4'b0000;
        end else begin
            ram_be_s    = 4'b0000;
        end
    end

    // Load lane assembly: in the first RESP cycle the RAM output holds the
    // base word (unsplit) or word+1 (split, base word saved in lo_word_q).
    always_comb begin
        lo_s = span_q ? lo_word_q : ram_rdata_s;
        case (addr_q[1:0])
            2'd0:    raw_s = lo_s;
            2'd1:    raw_s = {ram_rdata_s[7:0],  lo_s[31:8]};
            2'd2:    raw_s = {ram_rdata_s[15:0], lo_s[31:16]};
            2'd3:    raw_s = {ram_rdata_s[23:0], lo_s[31:24]};
            default: raw_s = lo_s;
        endcase
    end

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        span_d      = span_q;
        lo_word_d   = lo_word_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr[ADDR_W-1:0];
                    we_d        = req_we;
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    wdata_d     = req_wdata;
                    err_d       = req_err_s;
                    span_d      = req_span_s;
                    req_ready_d = 1'b0;
                    state_d     = ACC;
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            ACC: begin
                state_d = span_q ? ACC2 : RESP;
            end
            ACC2: begin
                lo_word_d = ram_rdata_s;
                state_d   = RESP;
            end
            RESP: begin
                // First RESP cycle loads the response registers; afterwards
                // they hold until the initiator takes them.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (we_q || err_q) ? 32'd0
                                                  : extend_load(raw_s, size_q, uns_q);
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            span_q      <= 1'b0;
            lo_word_q   <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            span_q      <= span_d;
            lo_word_q   <= lo_word_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    dmem_ram #(
        .WORDS (DEPTH_BYTES / 4),
        .AW    (WORD_AW)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr_s),
        .be    (ram_be_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder on the far side of the load/store path. Serves one outstanding load or store from the memory pipeline stage over a valid/ready request channel and a valid/ready response channel.
- Byte-addressable, little-endian, word-organised storage.
- Handles byte, half and word accesses, sign or zero extension on loads, and misaligned accesses that span two words.
- Sits between the mem stage and the storage array, replacing direct combinational array access with a clocked, handshaked interface.

Parameters:
- DEPTH_BYTES, 65536, storage size in bytes; must be a power of two, at least 8.
- ADDR_W, 16, log2(DEPTH_BYTES); internal byte-address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
- req_unsigned  in  1  load zero-extend (lbu/lhu); ignored on stores
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  access fault

Behaviour:
- Reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE. Array contents are not reset (zero-initialised in simulation only).
- Handshake: a transfer occurs when valid&ready are high at a rising edge. req_ready=1 only in IDLE, so there is one outstanding request. rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready=1. Request inputs are captured at acceptance.
- FSM:
  - IDLE: on accept, go to ACC.
  - ACC: access word addr[ADDR_W-1:2]. If the access spans a word boundary (half at offset 3; word at offset 1–3), go to ACC2. Otherwise go to RESP.
  - ACC2: access word+1; wrap modulo the array, so the top word wraps to word 0. Go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE. req_ready rises the cycle after rsp_ready.
- Latency (accept edge T):
  - Aligned or within-word: rsp_valid at T+2.
  - Spanning: rsp_valid at T+3.
- Reads are synchronous, registered, one word per cycle. Lane bytes are assembled from one or two words by addr[1:0].
- Extension: byte/half are sign-extended from bit 7/15 unless req_unsigned=1.
- Stores: per-byte write enables. Bytes beyond req_size are never modified. A spanning store writes its low part in ACC and its high part in ACC2.
- Errors: rsp_err=1 with no array write and rdata=0 when either condition holds:
  - req_addr[31:ADDR_W] != 0
  - req_size == 3
- Error latency equals the aligned latency.
- Reset mid-operation: FSM returns to IDLE and any pending response is dropped. A spanning store interrupted between ACC and ACC2 leaves only its low bytes written. The initiator must reissue.

Optional Feature:
- DMEM_MISALIGN_TRAP_EN
  - Defined: any access with addr not aligned to its size (half with addr[0]=1; word with addr[1:0]!=0) returns rsp_err=1, rdata=0, no write, at the aligned latency. ACC2 is never entered.
  - Undefined: misaligned accesses are split as above, with no error.

Decomposition:
- Shared package/define file holds:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2
  - FSM state constants IDLE/ACC/ACC2/RESP
  - the macro name
- One sub-module, dmem_ram: a word array with 4 byte-lane write enables and a 1-cycle registered read port.
- Lane assembly and extension stay in the top level.

Test Plan:
- Store word 0x8765_4321 at 0x10, load word from 0x10 -> rdata 0x8765_4321, err 0, rsp_valid 2 cycles after accept.
- Load byte at 0x13 after the above: signed -> 0xFFFF_FF87; unsigned -> 0x0000_0087. Store byte 0xAA at 0x11, load word 0x10 -> 0x8765_AA21.
- Store word 0x1122_3344 at 0x0E (spanning), load word 0x0E -> 0x1122_3344 at T+3, load word 0x0C -> 0x3344_xxxx with the low half unchanged. With DMEM_MISALIGN_TRAP_EN defined: err=1, memory unchanged.
- Load at 0x0001_0000, and a request with req_size=3 -> err=1, rdata 0, no write. Read-back of 0x0 is unchanged.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp fields stable, req_ready=0, second request not accepted until the cycle after rsp_ready.
- Assert rst between ACC and ACC2 of a spanning store -> rsp_valid=0, req_ready=1 after reset, only low-word bytes modified.
